accum_result_buffer: RTL
========================

ACCUM_RESULT_BUFFER -- requirements
Module: accum_result_buffer

Interface
REQ-001 The module SHALL have parameter ADDRESSSIZE, default 10, meaning address width; depth = 2**ADDRESSSIZE words.
REQ-002 The module SHALL have parameter LANES, default 8, meaning signed result elements per word.
REQ-003 The module SHALL have parameter LANEW, default 20, meaning bits per lane; word width WORDSIZE = LANES*LANEW (default 160).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 clr_start  input  1  one-cycle pulse requesting all words be zeroed.
REQ-007 busy  output  1  high while clearing; high means wr/rd requests are ignored.
REQ-008 wr_valid  input  1  write request this cycle.
REQ-009 wr_accum  input  1  1 = add wr_data lane-wise to the stored word; 0 = overwrite.
REQ-010 wr_addr  input  ADDRESSSIZE  write address.
REQ-011 wr_data  input  WORDSIZE  write data, lane i at bits [i*LANEW +: LANEW].
REQ-012 rd_valid  input  1  read request this cycle.
REQ-013 rd_addr  input  ADDRESSSIZE  read address.
REQ-014 rd_data  output  WORDSIZE  read data.
REQ-015 rd_data_valid  output  1  high for exactly one cycle when rd_data is valid.

Function
REQ-016 Storage SHALL be one write port and one read port, usable in the same cycle, including to the same address.
REQ-017 An overwrite write accepted at edge t SHALL be visible in memory after edge t.
REQ-018 An accumulate write SHALL be a 2-stage pipeline: stage 1 fetches the old word; stage 2 commits old+wr_data at edge t+1.
REQ-019 Accumulate forwarding SHALL apply: if stage 2 holds the same address, stage 1 uses the stage-2 result instead of memory, so back-to-back accumulates to one address lose no update.
REQ-020 An overwrite to address A while an accumulate to A is in stage 2 SHALL win, so the final value is the overwrite data.
REQ-021 A read accepted at edge t SHALL drive rd_data and rd_data_valid=1 after edge t+1; it SHALL reflect every write accepted before edge t, forwarding from stage 2 where needed.
REQ-022 Lane arithmetic SHALL be signed two's complement, LANEW bits, with lanes independent and no carry between lanes.
REQ-023 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on clr_start while in IDLE.
REQ-024 In CLEAR, one word per cycle SHALL be zeroed starting at address 0; after address 2**ADDRESSSIZE-1 the FSM SHALL return to IDLE, and the clear counter SHALL wrap to 0.
REQ-025 busy SHALL be 1 exactly while in CLEAR; clr_start in CLEAR SHALL be ignored.
REQ-026 An accumulate in flight when clr_start arrives SHALL complete before zeroing begins at address 0; in that case the CLEAR entry is delayed by at most 1 cycle.
REQ-027 rd_data SHALL hold its last value when rd_data_valid=0.

Reset
REQ-028 While rst_n=0: FSM=IDLE, busy=0, rd_data_valid=0, rd_data=0, pipeline valid bits=0, clear counter=0.
REQ-029 Memory contents SHALL NOT be reset; reset mid-CLEAR or mid-accumulate abandons the operation and leaves memory partially updated.

Configuration
REQ-030 With macro ACCUM_SAT_EN defined, accumulate SHALL saturate per lane to [-2**(LANEW-1), 2**(LANEW-1)-1].
REQ-031 Without ACCUM_SAT_EN, accumulate SHALL wrap modulo 2**LANEW.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding, default LANES/LANEW/ADDRESSSIZE constants, and lane min/max constants.
REQ-033 A sub-module accum_lane_add, one LANEW-bit signed adder with optional saturation, SHALL be instantiated LANES times.

Verification
REQ-034 Overwrite addr 5 with lane0=7 and other lanes 0, then read addr 5 -> rd_data lane0=7 two edges after the write and rd_data_valid one cycle.
REQ-035 Four back-to-back accumulates of lane0=+3 to addr 9 (starting at 0), then read -> lane0=12, with no lost update.
REQ-036 Lane0 = 2**(LANEW-1)-1, accumulate +1 -> -2**(LANEW-1) without ACCUM_SAT_EN, or unchanged with ACCUM_SAT_EN.
REQ-037 clr_start with ADDRESSSIZE=4 -> busy high exactly 16 cycles, reads/writes during busy have no effect, all words read 0 afterward.
REQ-038 Write addr 3 and read addr 3 in the same cycle -> read returns the pre-write value; a read one cycle later returns the new value.
REQ-039 Assert rst_n=0 mid-CLEAR -> busy=0 and rd_data_valid=0 immediately, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/accum_result_buffer_pkg.sv
// Shared types and constants for the accumulating result buffer.
// Optional build macro: ACCUM_SAT_EN (per-lane saturating accumulate).
package accum_result_buffer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int DEF_ADDRESSSIZE = 10;
    localparam int DEF_LANES       = 8;
    localparam int DEF_LANEW       = 20;

    localparam logic signed [DEF_LANEW-1:0] DEF_LANE_MAX = {1'b0, {(DEF_LANEW-1){1'b1}}};
    localparam logic signed [DEF_LANEW-1:0] DEF_LANE_MIN = {1'b1, {(DEF_LANEW-1){1'b0}}};

endpackage

// File: rtl/accum_result_buffer_lane_add.sv
// One signed lane adder: wraps by default, saturates when ACCUM_SAT_EN is defined.
module accum_lane_add
    import accum_result_buffer_pkg::*;
#(
    parameter int LANEW = DEF_LANEW
) (
    input  logic [LANEW-1:0] a_i,
    input  logic [LANEW-1:0] b_i,
    output logic [LANEW-1:0] sum_o
);

`ifdef ACCUM_SAT_EN
    logic [LANEW:0] wide;

    assign wide = {a_i[LANEW-1], a_i} + {b_i[LANEW-1], b_i};

    // Signed overflow shows up as the two top bits of the widened sum disagreeing.
    always_comb begin
        sum_o = wide[LANEW-1:0];
        if (wide[LANEW] != wide[LANEW-1]) begin
            sum_o = wide[LANEW] ? {1'b1, {(LANEW-1){1'b0}}} : {1'b0, {(LANEW-1){1'b1}}};
        end
    end
`else
    assign sum_o = a_i + b_i;
`endif

endmodule

// File: rtl/accum_result_buffer.sv
// Result buffer with overwrite/accumulate writes, 2-cycle reads and a bulk clear FSM.
// Optional build macro: ACCUM_SAT_EN. Requests (wr_valid/rd_valid/clr_start) are single-cycle
// strobes taken when busy=0; there is no backpressure, and rd_data_valid is a one-cycle strobe.
module accum_result_buffer
    import accum_result_buffer_pkg::*;
#(
    parameter int ADDRESSSIZE = DEF_ADDRESSSIZE,
    parameter int LANES       = DEF_LANES,
    parameter int LANEW       = DEF_LANEW,
    localparam int WORDSIZE   = LANES * LANEW,
    localparam int DEPTH      = 2 ** ADDRESSSIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_start,
    output logic                   busy,
    input  logic                   wr_valid,
    input  logic                   wr_accum,
    input  logic [ADDRESSSIZE-1:0] wr_addr,
    input  logic [WORDSIZE-1:0]    wr_data,
    input  logic                   rd_valid,
    input  logic [ADDRESSSIZE-1:0] rd_addr,
    output logic [WORDSIZE-1:0]    rd_data,
    output logic                   rd_data_valid,
    output state_e                 fsm_state
);

    logic [WORDSIZE-1:0]    mem_q [DEPTH];

    state_e                 state_q, state_d;
    logic [ADDRESSSIZE-1:0] clr_cnt_q, clr_cnt_d;

    logic                   s2_valid_q;
    logic [ADDRESSSIZE-1:0] s2_addr_q;
    logic [WORDSIZE-1:0]    s2_old_q;
    logic [WORDSIZE-1:0]    s2_data_q;
    logic [WORDSIZE-1:0]    s2_sum;

    logic                   r1_valid_q;
    logic [WORDSIZE-1:0]    r1_word_q;
    logic                   rd_valid_q;
    logic [WORDSIZE-1:0]    rd_data_q;

    logic                   ovw_ok, acc_ok, rd_ok;
    logic [WORDSIZE-1:0]    acc_old, rd_word;

    assign busy          = (state_q == ST_CLEAR);
    assign fsm_state     = state_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;

    assign ovw_ok = wr_valid & ~wr_accum & ~busy;
    assign acc_ok = wr_valid &  wr_accum & ~busy;
    assign rd_ok  = rd_valid & ~busy;

    // Stage 2 holds the newest value of its address until it commits, so look there first.
    assign acc_old = (s2_valid_q && s2_addr_q == wr_addr) ? s2_sum : mem_q[wr_addr];
    assign rd_word = (s2_valid_q && s2_addr_q == rd_addr) ? s2_sum : mem_q[rd_addr];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        accum_lane_add #(.LANEW(LANEW)) u_add (
            .a_i   (s2_old_q[i*LANEW +: LANEW]),
            .b_i   (s2_data_q[i*LANEW +: LANEW]),
            .sum_o (s2_sum[i*LANEW +: LANEW])
        );
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDRESSSIZE'(1);
                if (clr_cnt_q == {ADDRESSSIZE{1'b1}}) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_old_q   <= '0;
            s2_data_q  <= '0;
            r1_valid_q <= 1'b0;
            r1_word_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            s2_valid_q <= acc_ok;
            if (acc_ok) begin
                s2_addr_q <= wr_addr;
                s2_old_q  <= acc_old;
                s2_data_q <= wr_data;
            end
            r1_valid_q <= rd_ok;
            if (rd_ok) r1_word_q <= rd_word;
            rd_valid_q <= r1_valid_q;
            if (r1_valid_q) rd_data_q <= r1_word_q;
        end
    end

    // Later assignments win on a shared address: a clear or an overwrite beats a pending commit.
    // A commit coinciding with the first clear write therefore lands before the zeroing.
    always_ff @(posedge clk) begin
        if (s2_valid_q) mem_q[s2_addr_q] <= s2_sum;
        if (busy)       mem_q[clr_cnt_q] <= '0;
        if (ovw_ok)     mem_q[wr_addr]   <= wr_data;
    end

endmodule
